ksa_share_arb: RTL and testbench

- Round-robin arbiter and 2-stage pipeline sequencer that shares one ksa_top_32b_32 Kogge-Stone adder among NREQ requesters, e.g. the butterfly real/imag add/sub paths of the 64-point FFT.
- Grants one operand pair per cycle and issues it to the adder with add/subtract control via the adder's c0 and a b inversion.
- Returns each tagged result through a valid/ready output port.

---
 rtl/ksa_pkg.sv | 22 ++
 rtl/ksa_top_32b_32.sv | 37 +++
 rtl/rr_arb_n.sv | 34 +++
 rtl/ksa_share_arb.sv | 112 +++++++++++
 tb/tb_ksa_share_arb.sv | 259 +++++++++++++++++++++++++
 5 files changed

// File: rtl/ksa_pkg.sv
// Shared types for the Kogge-Stone sharing arbiter: pipeline stage records
// and the adder width. ID fields are sized for the largest legal NREQ (8).
package ksa_pkg;

    localparam int KSA_W   = 32;
    localparam int ID_MAXW = 3;

    typedef struct packed {
        logic [KSA_W-1:0]   a;
        logic [KSA_W-1:0]   b_eff;
        logic               c0;
        logic [ID_MAXW-1:0] id;
    } s1_rec_t;

    typedef struct packed {
        logic [KSA_W-1:0]   s;
        logic               carry;
        logic               ovf;
        logic [ID_MAXW-1:0] id;
    } s2_rec_t;

endpackage

// File: rtl/ksa_top_32b_32.sv
// 32-bit Kogge-Stone adder with carry-in; purely combinational.
module ksa_top_32b_32 (
    input  logic        c0_i,
    input  logic [31:0] a_i,
    input  logic [31:0] b_i,
    output logic [31:0] s_o,
    output logic        cout_o
);

    logic [5:0][31:0] g;
    logic [5:0][31:0] p;
    logic             unused_p;

    always_comb begin
        g = '0;
        p = '0;
        // Carry-in folds into bit 0 generate so the prefix tree needs no extra column.
        p[0] = a_i ^ b_i;
        g[0] = (a_i & b_i) | {31'b0, p[0][0] & c0_i};
        for (int l = 0; l < 5; l++) begin
            for (int i = 0; i < 32; i++) begin
                if (i >= (1 << l)) begin
                    g[l+1][i] = g[l][i] | (p[l][i] & g[l][i-(1<<l)]);
                    p[l+1][i] = p[l][i] & p[l][i-(1<<l)];
                end else begin
                    g[l+1][i] = g[l][i];
                    p[l+1][i] = p[l][i];
                end
            end
        end
    end

    assign s_o      = p[0] ^ {g[5][30:0], c0_i};
    assign cout_o   = g[5][31];
    assign unused_p = ^p[5];

endmodule

// File: rtl/rr_arb_n.sv
// Parameterised round-robin arbiter: first requester at or above ptr_i wins,
// wrapping N-1 -> 0. Grant is one-hot and never set for an idle requester.
module rr_arb_n #(
    parameter int N  = 4,
    parameter int IW = 2
) (
    input  logic [N-1:0]  req_i,
    input  logic [IW-1:0] ptr_i,
    input  logic          en_i,
    output logic [N-1:0]  gnt_o,
    output logic [IW-1:0] idx_o
);

    logic found;
    int   k;

    always_comb begin
        gnt_o = '0;
        idx_o = '0;
        found = 1'b0;
        k     = 0;
        if (en_i) begin
            for (int i = 0; i < N; i++) begin
                k = (int'(ptr_i) + i) % N;
                if (!found && req_i[k]) begin
                    found    = 1'b1;
                    gnt_o[k] = 1'b1;
                    idx_o    = IW'(k);
                end
            end
        end
    end

endmodule

// File: rtl/ksa_share_arb.sv
// Shares one Kogge-Stone adder among NREQ requesters: round-robin grant into
// an operand stage, adder, then a result stage driving a valid/ready port.
module ksa_share_arb
    import ksa_pkg::*;
#(
    parameter int NREQ = 4,
    parameter int IDW  = 2
) (
    input  logic                  i_clk,
    input  logic                  i_rst,
    input  logic [NREQ-1:0]       i_req_valid,
    output logic [NREQ-1:0]       o_req_ready,
    input  logic [KSA_W*NREQ-1:0] i_req_a,
    input  logic [KSA_W*NREQ-1:0] i_req_b,
    input  logic [NREQ-1:0]       i_req_sub,
    output logic                  o_res_valid,
    input  logic                  i_res_ready,
    output logic [KSA_W-1:0]      o_res_s,
    output logic                  o_res_carry,
    output logic                  o_res_ovf,
    output logic [IDW-1:0]        o_res_id,
    output logic                  o_busy
);

    logic [IDW-1:0]   ptr_q, ptr_d;
    s1_rec_t          s1_q, s1_d;
    s2_rec_t          s2_q, s2_d;
    logic             v1_q, v2_q;
    logic             adv1, adv2;
    logic [NREQ-1:0]  gnt;
    logic [IDW-1:0]   gnt_idx;
    logic [KSA_W-1:0] sum;
    logic             cout;

    assign adv2 = !v2_q || i_res_ready;
    assign adv1 = !v1_q || adv2;

    // Reset gates the enable so no requester sees ready while held in reset.
    rr_arb_n #(.N(NREQ), .IW(IDW)) u_arb (
        .req_i (i_req_valid),
        .ptr_i (ptr_q),
        .en_i  (adv1 && !i_rst),
        .gnt_o (gnt),
        .idx_o (gnt_idx)
    );

    assign o_req_ready = gnt;

    always_comb begin
        s1_d       = '0;
        s1_d.a     = i_req_a[int'(gnt_idx)*KSA_W +: KSA_W];
        s1_d.c0    = i_req_sub[gnt_idx];
        s1_d.b_eff = s1_d.c0 ? ~i_req_b[int'(gnt_idx)*KSA_W +: KSA_W]
                             :  i_req_b[int'(gnt_idx)*KSA_W +: KSA_W];
        s1_d.id    = ID_MAXW'(gnt_idx);

        ptr_d = ptr_q;
        if (|gnt)
            ptr_d = (int'(gnt_idx) == NREQ-1) ? '0 : gnt_idx + 1'b1;
    end

    ksa_top_32b_32 u_ksa (
        .c0_i   (s1_q.c0),
        .a_i    (s1_q.a),
        .b_i    (s1_q.b_eff),
        .s_o    (sum),
        .cout_o (cout)
    );

    always_comb begin
        s2_d       = '0;
        s2_d.s     = sum;
        s2_d.carry = cout;
        s2_d.ovf   = (s1_q.a[KSA_W-1] == s1_q.b_eff[KSA_W-1]) && (sum[KSA_W-1] != s1_q.a[KSA_W-1]);
        s2_d.id    = s1_q.id;
    end

    always_ff @(posedge i_clk) begin
        if (i_rst) begin
            ptr_q <= '0;
            v1_q  <= 1'b0;
            v2_q  <= 1'b0;
            s1_q  <= '0;
            s2_q  <= '0;
        end else begin
            ptr_q <= ptr_d;
            if (adv1) begin
                s1_q <= s1_d;
                v1_q <= |gnt;
            end
            if (adv2) begin
                s2_q <= s2_d;
                v2_q <= v1_q;
            end
        end
    end

    assign o_res_valid = v2_q;
    assign o_res_s     = s2_q.s;
    assign o_res_carry = s2_q.carry;
    assign o_res_ovf   = s2_q.ovf;
    assign o_res_id    = s2_q.id[IDW-1:0];
    assign o_busy      = v1_q | v2_q;

    generate
        if (IDW < ID_MAXW) begin : g_id_pad
            logic unused_id;
            assign unused_id = ^s2_q.id[ID_MAXW-1:IDW];
        end
    endgenerate

endmodule

// File: tb/tb_ksa_share_arb.sv
// Directed bench for ksa_share_arb with a scoreboard of expected results
// pushed on each accepted grant and popped on each output handshake.
module tb_ksa_share_arb;

    localparam int NREQ = 4;
    localparam int IDW  = 2;

    logic                 i_clk = 1'b0;
    logic                 i_rst;
    logic [NREQ-1:0]      i_req_valid;
    logic [NREQ-1:0]      o_req_ready;
    logic [32*NREQ-1:0]   i_req_a;
    logic [32*NREQ-1:0]   i_req_b;
    logic [NREQ-1:0]      i_req_sub;
    logic                 o_res_valid;
    logic                 i_res_ready;
    logic [31:0]          o_res_s;
    logic                 o_res_carry;
    logic                 o_res_ovf;
    logic [IDW-1:0]       o_res_id;
    logic                 o_busy;

    always #5 i_clk = ~i_clk;

    ksa_share_arb #(.NREQ(NREQ), .IDW(IDW)) dut (
        .i_clk       (i_clk),
        .i_rst       (i_rst),
        .i_req_valid (i_req_valid),
        .o_req_ready (o_req_ready),
        .i_req_a     (i_req_a),
        .i_req_b     (i_req_b),
        .i_req_sub   (i_req_sub),
        .o_res_valid (o_res_valid),
        .i_res_ready (i_res_ready),
        .o_res_s     (o_res_s),
        .o_res_carry (o_res_carry),
        .o_res_ovf   (o_res_ovf),
        .o_res_id    (o_res_id),
        .o_busy      (o_busy)
    );

    typedef struct packed {
        logic [31:0]    s;
        logic           c;
        logic           o;
        logic [IDW-1:0] id;
    } exp_t;

    exp_t sb[$];
    int   checks = 0;
    int   errors = 0;

    function automatic exp_t model(logic [31:0] a, logic [31:0] b, logic sub, int id);
        exp_t        r;
        logic [31:0] be;
        logic [32:0] t;
        be   = sub ? ~b : b;
        t    = {1'b0, a} + {1'b0, be} + {32'b0, sub};
        r.s  = t[31:0];
        r.c  = t[32];
        r.o  = (a[31] == be[31]) && (t[31] != a[31]);
        r.id = IDW'(id);
        return r;
    endfunction

    task automatic chk(string tag, logic [63:0] obs, logic [63:0] expv);
        checks++;
        assert (obs === expv) else begin
            errors++;
            $error("FAIL %s obs=%0h exp=%0h", tag, obs, expv);
        end
    endtask

    task automatic step();
        @(posedge i_clk);
        #1;
    endtask

    task automatic set_req(int k, logic [31:0] a, logic [31:0] b, logic sub);
        i_req_a[32*k +: 32] = a;
        i_req_b[32*k +: 32] = b;
        i_req_sub[k]        = sub;
    endtask

    task automatic rand_req(int k);
        set_req(k, $urandom, $urandom, 1'($urandom_range(0, 1)));
    endtask

    // One isolated request from requester k, with hand-derived expectations.
    task automatic single(string tag, int k, logic [31:0] a, logic [31:0] b, logic sub,
                          logic [31:0] es, logic ec, logic eo);
        set_req(k, a, b, sub);
        i_req_valid    = '0;
        i_req_valid[k] = 1'b1;
        #1;
        chk({tag, "_grant"}, 64'(o_req_ready), 64'(1) << k);
        step();
        i_req_valid = '0;
        chk({tag, "_lat_nv"}, 64'(o_res_valid), 64'(0));
        step();
        chk({tag, "_valid"}, 64'(o_res_valid), 64'(1));
        chk({tag, "_s"},     64'(o_res_s),     64'(es));
        chk({tag, "_carry"}, 64'(o_res_carry), 64'(ec));
        chk({tag, "_ovf"},   64'(o_res_ovf),   64'(eo));
        chk({tag, "_id"},    64'(o_res_id),    64'(k));
        step();
    endtask

    task automatic drain(string tag);
        int n = 0;
        i_req_valid = '0;
        i_res_ready = 1'b1;
        while (o_busy && n < 20) begin
            step();
            n++;
        end
        chk({tag, "_idle"}, 64'(o_busy), 64'(0));
        step();
        chk({tag, "_sb_empty"}, 64'(sb.size()), 64'(0));
    endtask

    // Scoreboard: sample mid-cycle, where inputs and outputs are both settled.
    exp_t e;
    always @(negedge i_clk) begin
        if (i_rst) begin
            sb.delete();
        end else begin
            if (o_res_valid && i_res_ready) begin
                if (sb.size() == 0) begin
                    chk("unexpected_result", 64'(1), 64'(0));
                end else begin
                    e = sb.pop_front();
                    chk("sb_s",     64'(o_res_s),     64'(e.s));
                    chk("sb_carry", 64'(o_res_carry), 64'(e.c));
                    chk("sb_ovf",   64'(o_res_ovf),   64'(e.o));
                    chk("sb_id",    64'(o_res_id),    64'(e.id));
                end
            end
            for (int k = 0; k < NREQ; k++)
                if (o_req_ready[k])
                    sb.push_back(model(i_req_a[32*k +: 32], i_req_b[32*k +: 32], i_req_sub[k], k));
        end
    end

    logic [NREQ-1:0] rdy;
    logic [31:0]     s_hold;
    logic [IDW-1:0]  id_hold;
    int              acc;

    initial begin
        i_rst       = 1'b1;
        i_req_valid = '1;
        i_req_sub   = '0;
        i_res_ready = 1'b1;
        for (int k = 0; k < NREQ; k++) rand_req(k);

        // Reset with every requester valid: nothing granted, nothing presented.
        for (int c = 0; c < 2; c++) begin
            step();
            chk("rst_ready", 64'(o_req_ready), 64'(0));
            chk("rst_valid", 64'(o_res_valid), 64'(0));
            chk("rst_busy",  64'(o_busy),      64'(0));
        end
        chk("rst_s",     64'(o_res_s),     64'(0));
        chk("rst_carry", 64'(o_res_carry), 64'(0));
        chk("rst_ovf",   64'(o_res_ovf),   64'(0));
        chk("rst_id",    64'(o_res_id),    64'(0));

        i_rst = 1'b0;
        #1;
        chk("first_grant", 64'(o_req_ready), 64'(1));
        step();
        i_req_valid = '0;
        drain("post_rst");

        single("add", 1, 32'h7FFF_FFFF, 32'h0000_0001, 1'b0, 32'h8000_0000, 1'b0, 1'b1);
        single("sub_borrow", 2, 32'd5, 32'd7, 1'b1, 32'hFFFF_FFFE, 1'b0, 1'b0);
        single("sub_pos",    2, 32'd7, 32'd5, 1'b1, 32'h0000_0002, 1'b1, 1'b0);

        // Pointer sits at 3 after the last grant to requester 2.
        i_req_valid = '1;
        for (int k = 0; k < NREQ; k++) rand_req(k);
        #1;
        for (int i = 0; i < 12; i++) begin
            chk("rr_grant", 64'(o_req_ready), 64'(1) << ((3 + i) % NREQ));
            if (i >= 2) begin
                chk("rr_valid", 64'(o_res_valid), 64'(1));
                chk("rr_id",    64'(o_res_id),    64'((3 + i - 2) % NREQ));
            end
            rdy = o_req_ready;
            step();
            for (int k = 0; k < NREQ; k++) if (rdy[k]) rand_req(k);
            #1;
        end

        // Backpressure with both stages full: output frozen, no extra grant.
        i_res_ready = 1'b0;
        #1;
        s_hold  = o_res_s;
        id_hold = o_res_id;
        acc     = 0;
        for (int c = 0; c < 5; c++) begin
            acc += $countones(o_req_ready);
            rdy = o_req_ready;
            step();
            for (int k = 0; k < NREQ; k++) if (rdy[k]) rand_req(k);
            #1;
            chk("bp_valid", 64'(o_res_valid), 64'(1));
            chk("bp_s",     64'(o_res_s),     64'(s_hold));
            chk("bp_id",    64'(o_res_id),    64'(id_hold));
        end
        chk("bp_extra_le1", 64'(acc <= 1), 64'(1));
        i_res_ready = 1'b1;
        for (int c = 0; c < 4; c++) begin
            rdy = o_req_ready;
            step();
            for (int k = 0; k < NREQ; k++) if (rdy[k]) rand_req(k);
            #1;
        end
        drain("bp");

        // Skid: S2 held, S1 empty, so exactly one more request gets in.
        i_res_ready = 1'b0;
        rand_req(0);
        rand_req(1);
        i_req_valid = 4'b0001;
        step();
        i_req_valid = '0;
        step();
        i_req_valid = 4'b0010;
        #1;
        chk("skid_grant", 64'(o_req_ready), 64'(4'b0010));
        step();
        chk("skid_full", 64'(o_req_ready), 64'(0));
        chk("skid_busy", 64'(o_busy),      64'(1));
        drain("skid");

        // Reset while both stages hold data: in-flight results vanish.
        i_req_valid = '1;
        for (int k = 0; k < NREQ; k++) rand_req(k);
        step();
        step();
        step();
        chk("mr_busy_before", 64'(o_busy), 64'(1));
        i_rst = 1'b1;
        step();
        chk("mr_valid", 64'(o_res_valid), 64'(0));
        chk("mr_busy",  64'(o_busy),      64'(0));
        i_rst = 1'b0;
        #1;
        chk("mr_ptr0", 64'(o_req_ready), 64'(1));
        step();
        drain("mr");

        $display("CHECKS %0d ERRORS %0d", checks, errors);
        $finish;
    end

endmodule
